// File: rtl/shot_scoring_engine.sv
// Battleship shot scorer: validates a shot, then walks footprint plus ring over the ship map.
// Optional repeat-shot hit history is enabled by defining REPEAT_SHOT_FILTER_EN.
module shot_scoring_engine #(
  parameter int GRID       = 10,
  parameter int COORD_W    = 4,
  parameter int BIG_RADIUS = 1,
  parameter int BIG_BOMBS  = 2,
  parameter int SHIP_W     = 5,
  localparam int CNT_W = $clog2((2*BIG_RADIUS+1)**2+1),
  localparam int BL_W  = $clog2(BIG_BOMBS+1)
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               newGame,
  input  logic               scoreThis,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               big,
  output logic               busy,
  output logic               done,
  output logic               somethingWrong,
  output logic               isHit,
  output logic               isNearMiss,
  output logic               isMiss,
  output logic [SHIP_W-1:0]  biggestShip,
  output logic [CNT_W-1:0]   numHit,
  output logic [BL_W-1:0]    bigLeft,
  output logic [COORD_W-1:0] mapX,
  output logic [COORD_W-1:0] mapY,
  input  logic [SHIP_W-1:0]  mapShip
);

  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] ONE = SW'(1);
  localparam logic signed [SW-1:0] GS  = SW'(GRID);
  localparam logic [COORD_W-1:0]   GX  = COORD_W'(GRID);
  localparam logic [BL_W-1:0]      BLR = BL_W'(BIG_BOMBS);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, FIN} state_t;

  state_t state;
  logic [COORD_W-1:0] xl, yl;
  logic bl, wrong, near;
  logic signed [SW-1:0] dx, dy, lim, lim_c;
  logic signed [SW-1:0] cx, cy, ax, ay;
  logic [SHIP_W-1:0] acc, ship_ok;
  logic [CNT_W-1:0] cnt;
  logic bad, in_rng, foot, ring, hit, near_c, seen;

`ifdef REPEAT_SHOT_FILTER_EN
  localparam int HW = $clog2(GRID*GRID);
  logic [GRID*GRID-1:0] hist;
  logic [HW-1:0] idx;
  assign idx  = HW'(32'(cy - ONE) * GRID + 32'(cx - ONE));
  assign seen = in_rng && hist[idx];
`else
  assign seen = 1'b0;
`endif

  function automatic logic [SHIP_W-1:0] top_bit(input logic [SHIP_W-1:0] a);
    logic [SHIP_W-1:0] r;
    r = '0;
    for (int i = 0; i < SHIP_W; i++)
      if (a[i]) begin
        r = '0;
        r[i] = 1'b1;
      end
    return r;
  endfunction

  assign bad = (xl < COORD_W'(1)) || (xl > GX) ||
               (yl < COORD_W'(1)) || (yl > GX) ||
               (bl && bigLeft == '0);
  assign lim_c = bl ? SW'(BIG_RADIUS + 1) : ONE;

  // Offsets span -lim..lim; lim-1 is the footprint radius.
  assign cx = $signed({2'b00, xl}) + dx;
  assign cy = $signed({2'b00, yl}) + dy;
  assign ax = dx[SW-1] ? -dx : dx;
  assign ay = dy[SW-1] ? -dy : dy;
  assign in_rng  = (cx >= ONE) && (cx <= GS) && (cy >= ONE) && (cy <= GS);
  assign ship_ok = in_rng ? mapShip : '0;
  assign foot    = (ax < lim) && (ay < lim);
  assign ring    = (ax == lim) ^ (ay == lim);
  assign hit     = (state == SCAN) && foot && (|ship_ok) && !seen;
  assign near_c  = (state == SCAN) && ring && (|ship_ok);

  assign mapX = (state == SCAN) ? cx[COORD_W-1:0] : '0;
  assign mapY = (state == SCAN) ? cy[COORD_W-1:0] : '0;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      xl <= '0; yl <= '0; bl <= 1'b0;
      wrong <= 1'b0; near <= 1'b0;
      dx <= '0; dy <= '0; lim <= '0;
      acc <= '0; cnt <= '0;
      busy <= 1'b0; done <= 1'b0;
      somethingWrong <= 1'b0; isHit <= 1'b0;
      isNearMiss <= 1'b0; isMiss <= 1'b0;
      biggestShip <= '0; numHit <= '0;
      bigLeft <= BLR;
`ifdef REPEAT_SHOT_FILTER_EN
      hist <= '0;
`endif
    end else if (newGame) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0;
      somethingWrong <= 1'b0; isHit <= 1'b0;
      isNearMiss <= 1'b0; isMiss <= 1'b0;
      biggestShip <= '0; numHit <= '0;
      bigLeft <= BLR;
`ifdef REPEAT_SHOT_FILTER_EN
      hist <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (scoreThis) begin
          xl <= X; yl <= Y; bl <= big;
          busy <= 1'b1;
          somethingWrong <= 1'b0; isHit <= 1'b0;
          isNearMiss <= 1'b0; isMiss <= 1'b0;
          biggestShip <= '0; numHit <= '0;
          state <= CHECK;
        end
        CHECK: begin
          wrong <= bad;
          acc <= '0; cnt <= '0; near <= 1'b0;
          lim <= lim_c; dx <= -lim_c; dy <= -lim_c;
          if (bad) state <= FIN;
          else begin
            if (bl) bigLeft <= bigLeft - BL_W'(1);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc | ship_ok;
`ifdef REPEAT_SHOT_FILTER_EN
            hist[idx] <= 1'b1;
`endif
          end
          if (near_c) near <= 1'b1;
          if (dx == lim) begin
            dx <= -lim;
            if (dy == lim) state <= FIN;
            else dy <= dy + ONE;
          end else dx <= dx + ONE;
        end
        FIN: begin
          done <= 1'b1; busy <= 1'b0;
          somethingWrong <= wrong;
          if (!wrong) begin
            isHit <= (cnt != '0);
            isMiss <= (cnt == '0);
            isNearMiss <= near && (cnt == '0);
            biggestShip <= top_bit(acc);
            numHit <= cnt;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
